// File: rtl/mcoi_link_pkg.sv
// Shared types and constants for the MCOI link reset sequencer.
package mcoi_link_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    WAIT_LOS  = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4
  } t_link_seq_state;

  localparam int                     LOS_COUNT_W   = 16;
  localparam logic [LOS_COUNT_W-1:0] LOS_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mcoi_sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level; resets to 0.
module mcoi_sync_2ff (
  input  logic clk_ik,
  input  logic rst_ir,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_ik) begin
    if (rst_ir) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mcoi_link_reset_sequencer.sv
// Link reset sequencer: holds link reset until PLL lock and a clean LOS interval, counts LOS drops.
// Build option MCOI_LINK_LOS_COUNTER_EN adds the 16-bit LOS event counter and its clear input.
module mcoi_link_reset_sequencer
  import mcoi_link_pkg::*;
#(
  parameter int LOS_FILTER_CYCLES = 16,
  parameter int HOLD_CYCLES       = 1000,
  parameter int STABLE_CYCLES     = 100000
) (
  input  logic                   clk_ik,
  input  logic                   rst_ir,
  input  logic                   los_i,
  input  logic                   pll_locked_i,
  input  logic                   clear_count_i,
  output logic                   link_reset_o,
  output logic                   ready_o,
  output logic [LOS_COUNT_W-1:0] los_count_o,
  output logic [2:0]             state_o
);

  localparam int FILT_W = $clog2(LOS_FILTER_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(LOS_FILTER_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic los_s;
  logic lock_s;
  logic los_f;
  logic los_event;

  t_link_seq_state   state_q, state_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              link_reset_q;
  logic              ready_q;

  mcoi_sync_2ff u_sync_los (
    .clk_ik (clk_ik),
    .rst_ir (rst_ir),
    .d_i    (los_i),
    .q_o    (los_s)
  );

  mcoi_sync_2ff u_sync_lock (
    .clk_ik (clk_ik),
    .rst_ir (rst_ir),
    .d_i    (pll_locked_i),
    .q_o    (lock_s)
  );

  // Glitch filter: saturates at the threshold so los_f stays up for the whole LOS episode.
  assign los_f = (filt_q == FILT_MAX);

  always_comb begin
    filt_d = '0;
    if (los_s) begin
      filt_d = los_f ? filt_q : filt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stab_d    = stab_q;
    los_event = 1'b0;
    case (state_q)
      HOLD: begin
        if (hold_q == HOLD_LAST) state_d = WAIT_LOCK;
        else                     hold_d  = hold_q + 1'b1;
      end
      WAIT_LOCK: begin
        if (lock_s) state_d = WAIT_LOS;
      end
      WAIT_LOS: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (!los_s) begin
          state_d = STABLE;
          stab_d  = '0;
        end
      end
      STABLE: begin
        if (!lock_s)                state_d = WAIT_LOCK;
        else if (los_s)             state_d = WAIT_LOS;
        else if (stab_q == STAB_LAST) state_d = RUN;
        else                        stab_d  = stab_q + 1'b1;
      end
      RUN: begin
        if (!lock_s || los_f) begin
          state_d   = HOLD;
          hold_d    = '0;
          los_event = los_f;
        end
      end
      default: begin
        state_d = HOLD;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_ik) begin
    if (rst_ir) begin
      state_q      <= HOLD;
      filt_q       <= '0;
      hold_q       <= '0;
      stab_q       <= '0;
      link_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      filt_q       <= filt_d;
      hold_q       <= hold_d;
      stab_q       <= stab_d;
      link_reset_q <= (state_d != RUN);
      ready_q      <= (state_d == RUN);
    end
  end

  assign link_reset_o = link_reset_q;
  assign ready_o      = ready_q;
  assign state_o      = state_q;

`ifdef MCOI_LINK_LOS_COUNTER_EN
  logic [LOS_COUNT_W-1:0] los_count_q, los_count_d;

  // A clear coinciding with an event leaves exactly that one event counted.
  always_comb begin
    los_count_d = los_count_q;
    if (clear_count_i) begin
      los_count_d = {{(LOS_COUNT_W-1){1'b0}}, los_event};
    end else if (los_event && (los_count_q != LOS_COUNT_MAX)) begin
      los_count_d = los_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_ik) begin
    if (rst_ir) los_count_q <= '0;
    else        los_count_q <= los_count_d;
  end

  assign los_count_o = los_count_q;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = clear_count_i ^ los_event;
  assign los_count_o       = '0;
`endif

endmodule

// File: tb/tb_mcoi_link_reset_sequencer.sv
// Directed bench for mcoi_link_reset_sequencer with HOLD=10, STABLE=20, LOS filter=16.
module tb_mcoi_link_reset_sequencer;

`ifdef MCOI_LINK_LOS_COUNTER_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic        clk_ik = 1'b0;
  logic        rst_ir;
  logic        los_i;
  logic        pll_locked_i;
  logic        clear_count_i;
  logic        link_reset_o;
  logic        ready_o;
  logic [15:0] los_count_o;
  logic [2:0]  state_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_ik = ~clk_ik;

  mcoi_link_reset_sequencer #(
    .LOS_FILTER_CYCLES (16),
    .HOLD_CYCLES       (10),
    .STABLE_CYCLES     (20)
  ) dut (
    .clk_ik        (clk_ik),
    .rst_ir        (rst_ir),
    .los_i         (los_i),
    .pll_locked_i  (pll_locked_i),
    .clear_count_i (clear_count_i),
    .link_reset_o  (link_reset_o),
    .ready_o       (ready_o),
    .los_count_o   (los_count_o),
    .state_o       (state_o)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_ik);
      #1;
    end
  endtask

  // Edges until ready_o is seen high, capped at 200.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (ready_o !== 1'b1 && n < 200);
  endtask

  task automatic test_reset;
    rst_ir = 1'b1; los_i = 1'b0; pll_locked_i = 1'b1; clear_count_i = 1'b0;
    tick(3);
    vectors++;
    if (link_reset_o !== 1'b1) begin miscompares++; $display("FAIL reset_link_reset got %b want 1", link_reset_o); end
    vectors++;
    if (ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready_o); end
    vectors++;
    if (state_o !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", state_o); end
    vectors++;
    if (los_count_o !== 16'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", los_count_o); end
  endtask

  task automatic test_clean_start;
    int first_ready;
    first_ready = 0;
    rst_ir = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick(1);
      if (ready_o === 1'b1 && first_ready == 0) first_ready = i;
      if (i == 10) begin
        vectors++;
        if (state_o !== 3'd1) begin miscompares++; $display("FAIL start_wait_lock got %0d want 1", state_o); end
      end
      if (i == 12) begin
        vectors++;
        if (state_o !== 3'd3) begin miscompares++; $display("FAIL start_stable got %0d want 3", state_o); end
      end
      if (i == 31) begin
        vectors++;
        if (link_reset_o !== 1'b1) begin miscompares++; $display("FAIL start_reset_held got %b want 1", link_reset_o); end
      end
    end
    vectors++;
    if (first_ready != 32) begin miscompares++; $display("FAIL start_ready_edge got %0d want 32", first_ready); end
    vectors++;
    if (link_reset_o !== 1'b0 || state_o !== 3'd4) begin
      miscompares++; $display("FAIL start_released got reset=%b state=%0d want reset=0 state=4", link_reset_o, state_o);
    end
  endtask

  task automatic test_los_filter;
    int dropped;
    int first;
    int n;
    dropped = 0;
    los_i = 1'b1;
    tick(10);
    los_i = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (ready_o !== 1'b1) dropped++;
      tick(1);
    end
    vectors++;
    if (dropped != 0 || ready_o !== 1'b1) begin
      miscompares++; $display("FAIL glitch_kept_run got %0d drops ready=%b want 0 drops ready=1", dropped, ready_o);
    end
    first = 0;
    los_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (link_reset_o === 1'b1 && first == 0) first = i;
    end
    los_i = 1'b0;
    vectors++;
    if (first != 19) begin miscompares++; $display("FAIL los_latency got %0d want 19", first); end
    vectors++;
    if (los_count_o !== 16'(CNT_EN)) begin miscompares++; $display("FAIL los_count got %0d want %0d", los_count_o, CNT_EN); end
    wait_ready(n);
    vectors++;
    if (n != 31) begin miscompares++; $display("FAIL los_recover got %0d want 31", n); end
  endtask

  task automatic test_lock_loss;
    int n;
    n = 0;
    pll_locked_i = 1'b0;
    do begin
      tick(1);
      n++;
    end while (link_reset_o !== 1'b1 && n < 10);
    pll_locked_i = 1'b1;
    vectors++;
    if (n != 3) begin miscompares++; $display("FAIL lock_latency got %0d want 3", n); end
    vectors++;
    if (los_count_o !== 16'(CNT_EN)) begin miscompares++; $display("FAIL lock_count got %0d want %0d", los_count_o, CNT_EN); end
    wait_ready(n);
    vectors++;
    if (n != 32) begin miscompares++; $display("FAIL lock_recover got %0d want 32", n); end
  endtask

  task automatic test_unstable;
    int n;
    pll_locked_i = 1'b0;
    tick(3);
    pll_locked_i = 1'b1;
    tick(27);
    vectors++;
    if (state_o !== 3'd3) begin miscompares++; $display("FAIL unstable_in_stable got %0d want 3", state_o); end
    los_i = 1'b1;
    tick(1);
    los_i = 1'b0;
    tick(2);
    vectors++;
    if (state_o !== 3'd2) begin miscompares++; $display("FAIL unstable_back_wait_los got %0d want 2", state_o); end
    tick(1);
    vectors++;
    if (state_o !== 3'd3) begin miscompares++; $display("FAIL unstable_restable got %0d want 3", state_o); end
    wait_ready(n);
    vectors++;
    if (n != 20) begin miscompares++; $display("FAIL unstable_full_period got %0d want 20", n); end
  endtask

  task automatic test_reset_mid_stable;
    int n;
    pll_locked_i = 1'b0;
    tick(3);
    pll_locked_i = 1'b1;
    tick(15);
    vectors++;
    if (state_o !== 3'd3) begin miscompares++; $display("FAIL midrst_in_stable got %0d want 3", state_o); end
    rst_ir = 1'b1;
    tick(1);
    rst_ir = 1'b0;
    vectors++;
    if (state_o !== 3'd0 || link_reset_o !== 1'b1 || ready_o !== 1'b0) begin
      miscompares++; $display("FAIL midrst_outputs got state=%0d reset=%b ready=%b want 0 1 0", state_o, link_reset_o, ready_o);
    end
    vectors++;
    if (los_count_o !== 16'd0) begin miscompares++; $display("FAIL midrst_count got %0d want 0", los_count_o); end
    wait_ready(n);
    vectors++;
    if (n != 32) begin miscompares++; $display("FAIL midrst_restart got %0d want 32", n); end
  endtask

`ifdef MCOI_LINK_LOS_COUNTER_EN
  task automatic test_counter_edges;
    int n;
    dut.los_count_q = 16'hFFFE;
    for (int ev = 0; ev < 2; ev++) begin
      los_i = 1'b1;
      tick(20);
      los_i = 1'b0;
      vectors++;
      if (los_count_o !== 16'hFFFF) begin miscompares++; $display("FAIL cnt_saturate ev%0d got %h want ffff", ev, los_count_o); end
      wait_ready(n);
    end
    los_i = 1'b1;
    tick(18);
    clear_count_i = 1'b1;
    tick(1);
    clear_count_i = 1'b0;
    vectors++;
    if (link_reset_o !== 1'b1 || los_count_o !== 16'd1) begin
      miscompares++; $display("FAIL cnt_clear_with_event got reset=%b count=%0d want 1 1", link_reset_o, los_count_o);
    end
    tick(1);
    los_i = 1'b0;
    wait_ready(n);
    clear_count_i = 1'b1;
    tick(1);
    clear_count_i = 1'b0;
    vectors++;
    if (los_count_o !== 16'd0) begin miscompares++; $display("FAIL cnt_clear got %0d want 0", los_count_o); end
  endtask
`else
  task automatic test_counter_edges;
    los_i = 1'b1;
    tick(20);
    los_i = 1'b0;
    clear_count_i = 1'b1;
    tick(1);
    clear_count_i = 1'b0;
    vectors++;
    if (los_count_o !== 16'd0) begin miscompares++; $display("FAIL cnt_tied_zero got %0d want 0", los_count_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_start();
    test_los_filter();
    test_lock_loss();
    test_unstable();
    test_reset_mid_stable();
    test_counter_edges();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mcoi_link_reset_sequencer.md
# mcoi_link_reset_sequencer

Generates the system-wide link reset request that the clock/reset generation stage distributes into every clock domain. It synchronises the raw GBT loss-of-signal flag and the 40 MHz PLL lock, filters LOS glitches, and holds the link in reset until lock is present and the link has been clean for a programmable interval. It also counts LOS events for diagnostics. It runs in the free-running 100 MHz domain and drives the `reset` source net of the clock/reset stage.

## Interface

**Parameters**
- `LOS_FILTER_CYCLES`, default 16: consecutive synchronised LOS-high cycles needed to declare LOS in RUN. Must be ≥1.
- `HOLD_CYCLES`, default 1000: minimum link reset assertion length in cycles. Must be ≥1.
- `STABLE_CYCLES`, default 100000: clean cycles required (lock=1, LOS=0) before release. Must be ≥1.

**Ports**
- `clk_ik`, input, 1: 100 MHz free-running clock.
- `rst_ir`, input, 1: reset; synchronous, active-high.
- `los_i`, input, 1: raw GBT loss of signal; asynchronous.
- `pll_locked_i`, input, 1: 40 MHz PLL lock; asynchronous.
- `clear_count_i`, input, 1: single-cycle pulse that clears `los_count_o`.
- `link_reset_o`, output, 1: reset request to the clock/reset stage; active-high.
- `ready_o`, output, 1: link up; high only in RUN.
- `los_count_o`, output, 16: saturating count of LOS-triggered resets.
- `state_o`, output, 3: current FSM state encoding, for diagnostics.

## Operation

- **Input synchronisers.** `los_i` and `pll_locked_i` each pass through a 2-flop synchroniser, giving `los_s` and `lock_s`.
- **LOS filter.** A counter increments while `los_s`=1 and clears to 0 on `los_s`=0. `los_f` asserts when the counter reaches `LOS_FILTER_CYCLES`. The counter saturates there.
- **FSM states** (encoding in the package):
  - HOLD=0: the hold counter counts `HOLD_CYCLES` cycles, then goes to WAIT_LOCK. No input is evaluated.
  - WAIT_LOCK=1: when `lock_s`=1, go to WAIT_LOS.
  - WAIT_LOS=2: if `lock_s`=0, go to WAIT_LOCK. Otherwise, when `los_s`=0, go to STABLE and clear the stable counter.
  - STABLE=3: count cycles.
    - `lock_s`=0 → WAIT_LOCK. This has priority.
    - Otherwise `los_s`=1 → WAIT_LOS.
    - When the count reaches `STABLE_CYCLES`, go to RUN.
  - RUN=4:
    - `lock_s`=0 or `los_f`=1 → HOLD, and clear the hold counter.
- **Output decode.** Outputs are registered decodes of the next state, so they change on the same edge as the state register.
  - `link_reset_o` = (state≠RUN).
  - `ready_o` = (state==RUN).
- **LOS counter.** Increments by 1 on each RUN→HOLD transition where `los_f`=1.
  - If lock loss and `los_f` occur in the same cycle, the counter increments exactly once.
  - The counter saturates at 0xFFFF.
  - `clear_count_i` sets it to 0. If a clear and an increment occur in the same cycle, the result is 1.
- **Counter widths.** All internal counters are `$clog2(PARAM+1)` bits wide and unsigned. No wrap-around is permitted.

## Timing

- **Reset values** (apply while `rst_ir`=1):
  - state=HOLD, all counters 0, synchroniser flops 0.
  - `link_reset_o`=1, `ready_o`=0, `los_count_o`=0, `state_o`=0.
- **`rst_ir` mid-operation.** Behaviour is the reset values on the next edge, from any state. `los_count_o` is also cleared.
- **Input latency.** Synchroniser latency is 2 cycles.
- **LOS detection latency.** From `los_i` rising in RUN to `link_reset_o` high is 2 + `LOS_FILTER_CYCLES` + 1 cycles.
- **Lock loss latency.** From `pll_locked_i` falling in RUN to `link_reset_o` high is 3 cycles.
- **Release latency.** With inputs clean from reset, `ready_o` rises `HOLD_CYCLES` + 2 + `STABLE_CYCLES` cycles after the first edge with `rst_ir`=0.
- **`link_reset_o` minimum width.** Every assertion of `link_reset_o` lasts at least `HOLD_CYCLES` + 2 + `STABLE_CYCLES` cycles.

## Configuration

- Macro: `MCOI_LINK_LOS_COUNTER_EN`.
- **Defined:** the 16-bit LOS event counter and the `clear_count_i` logic are built.
- **Undefined:** no counter flops are built, and `los_count_o` is tied to 0. `clear_count_i` is ignored. The FSM and all other outputs are unchanged.

## Structure

- **Shared package `mcoi_link_pkg`:**
  - `typedef enum logic [2:0] t_link_seq_state` {HOLD, WAIT_LOCK, WAIT_LOS, STABLE, RUN}.
  - `localparam` `LOS_COUNT_W`=16.
  - `localparam` `LOS_COUNT_MAX`=16'hFFFF.
- **Sub-module `mcoi_sync_2ff`:** a generic 2-flop synchroniser with a reset-to-0 value. It is instantiated twice, once for `los_i` and once for `pll_locked_i`.

## Test plan

- **Clean start.** `HOLD_CYCLES`=10, `STABLE_CYCLES`=20, lock=1, LOS=0, `rst_ir` released → `ready_o` rises exactly 32 cycles later; `link_reset_o` falls on the same edge.
- **Filtered glitch.** In RUN, `LOS_FILTER_CYCLES`=16: `los_i` high for 10 cycles → no exit from RUN. `los_i` high for 20 cycles → `link_reset_o`=1 19 cycles after `los_i` rose, and `los_count_o`=1.
- **Lock loss.** In RUN, `pll_locked_i` falls → `link_reset_o`=1 after 3 cycles, `los_count_o` unchanged. Lock returns → `ready_o` again after 10+2+20 cycles.
- **Unstable link.** In STABLE, pulse `los_i` for 1 cycle at count 15 → state returns to WAIT_LOS, and a full 20-cycle STABLE period is required before RUN.
- **Counter edge cases.** With the macro defined, force the count to 0xFFFE, then trigger two LOS events → count is 0xFFFF both times. Assert `clear_count_i` in the same cycle as an event → count=1.
- **Reset mid-STABLE.** Assert `rst_ir` for 1 cycle mid-STABLE → next edge shows `state_o`=0, `link_reset_o`=1, `los_count_o`=0; the release sequence restarts from HOLD.
